commit_checker: RTL and testbench

COMMIT_CHECKER -- requirements
Module: commit_checker

---
 rtl/commit_chk_pkg.sv | 62 ++++++
 rtl/commit_fifo.sv | 53 +++++
 rtl/commit_checker.sv | 114 +++++++++++
 tb/tb_commit_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_chk_pkg.sv
// Commit-record types, field indices and the field compare rule for commit_checker.
// Define COMMIT_CHK_PRIV_EN to include the priv field in the compare.
package commit_chk_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        trap;
    logic [1:0]  priv;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

  // Bit positions inside mismatch_fields, following the struct field order.
  localparam int F_PC        = 0;
  localparam int F_INSTR     = 1;
  localparam int F_RD_ADDR   = 2;
  localparam int F_RD_DATA   = 3;
  localparam int F_MEM_WE    = 4;
  localparam int F_MEM_ADDR  = 5;
  localparam int F_MEM_WDATA = 6;
  localparam int F_TRAP      = 7;
  localparam int F_PRIV      = 8;
  localparam int NUM_FIELDS  = 9;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic {ST_RUN = 1'b0, ST_FAIL = 1'b1} chk_state_t;

  function automatic logic [NUM_FIELDS-1:0] cmp_fields(commit_rec_t d, commit_rec_t r);
    logic [NUM_FIELDS-1:0] m;
    m          = '0;
    m[F_PC]    = (d.pc != r.pc);
    m[F_TRAP]  = (d.trap != r.trap);
`ifdef COMMIT_CHK_PRIV_EN
    m[F_PRIV]  = (d.priv != r.priv);
`else
    m[F_PRIV]  = 1'b0;
`endif
    // A trap on both sides carries no architectural writeback worth comparing.
    if (!(d.trap && r.trap)) begin
      m[F_INSTR]   = (d.instr != r.instr);
      m[F_RD_ADDR] = (d.rd_addr != r.rd_addr);
      m[F_MEM_WE]  = (d.mem_we != r.mem_we);
      if ((d.rd_addr != 5'd0) || (r.rd_addr != 5'd0))
        m[F_RD_DATA] = (d.rd_data != r.rd_data);
      if (d.mem_we || r.mem_we) begin
        m[F_MEM_ADDR]  = (d.mem_addr != r.mem_addr);
        m[F_MEM_WDATA] = (d.mem_wdata != r.mem_wdata);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// DEPTH-entry commit record FIFO, head visible combinationally; caller guards push/pop.
module commit_fifo
  import commit_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [REC_W-1:0] push_dat,
  input  logic             pop,
  output logic [REC_W-1:0] head_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + AW'(1);
      if (pop)  r_rptr <= r_rptr + AW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head_dat = r_mem[r_rptr];
  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/commit_checker.sv
// Lockstep DUT-vs-reference retirement checker: records queue per side, heads pop together
// and compare; the result registers on the pop edge. Any error freezes state until clr.
module commit_checker
  import commit_chk_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  dut_valid,
  input  logic [REC_W-1:0]      dut_rec,
  input  logic                  ref_valid,
  input  logic [REC_W-1:0]      ref_rec,
  output logic                  mismatch,
  output logic [NUM_FIELDS-1:0] mismatch_fields,
  output logic [63:0]           mismatch_pc,
  output logic                  timeout_err,
  output logic                  overflow_err,
  output logic [31:0]           match_count,
  output logic                  running
);

  localparam int LW = $clog2(TIMEOUT + 1);

  chk_state_t             r_state;
  chk_state_t             w_state_nxt;
  logic [LW-1:0]          r_lead;
  logic [REC_W-1:0]       w_dut_head_raw, w_ref_head_raw;
  commit_rec_t            w_dut_head, w_ref_head;
  logic                   w_dut_empty, w_dut_full, w_ref_empty, w_ref_full;
  logic                   w_run, w_pop, w_dut_push, w_ref_push;
  logic                   w_ovf, w_tmo, w_mis, w_match, w_lead_one, w_err;
  logic [NUM_FIELDS-1:0]  w_fields;

  assign w_dut_head = w_dut_head_raw;
  assign w_ref_head = w_ref_head_raw;

  assign w_run      = (r_state == ST_RUN);
  assign w_pop      = w_run && !w_dut_empty && !w_ref_empty;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign w_dut_push = w_run && !clr && dut_valid && (!w_dut_full || w_pop);
  assign w_ref_push = w_run && !clr && ref_valid && (!w_ref_full || w_pop);
  assign w_ovf      = w_run && ((dut_valid && w_dut_full && !w_pop) ||
                                (ref_valid && w_ref_full && !w_pop));
  assign w_fields   = cmp_fields(w_dut_head, w_ref_head);
  assign w_mis      = w_pop && (|w_fields);
  assign w_match    = w_pop && !(|w_fields);
  assign w_lead_one = (w_dut_empty != w_ref_empty);
  assign w_tmo      = w_run && w_lead_one && (r_lead == LW'(TIMEOUT - 1));
  assign w_err      = w_mis || w_ovf || w_tmo;

  commit_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(w_dut_push), .push_dat(dut_rec), .pop(w_pop),
    .head_dat(w_dut_head_raw), .empty(w_dut_empty), .full(w_dut_full)
  );

  commit_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(w_ref_push), .push_dat(ref_rec), .pop(w_pop),
    .head_dat(w_ref_head_raw), .empty(w_ref_empty), .full(w_ref_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_err) w_state_nxt = ST_FAIL;
      ST_FAIL: w_state_nxt = ST_FAIL;
      default: w_state_nxt = ST_RUN;
    endcase
    if (clr) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch        <= 1'b0;
      mismatch_fields <= '0;
      mismatch_pc     <= '0;
      timeout_err     <= 1'b0;
      overflow_err    <= 1'b0;
      match_count     <= '0;
      r_lead          <= '0;
    end else if (clr) begin
      mismatch        <= 1'b0;
      mismatch_fields <= '0;
      mismatch_pc     <= '0;
      timeout_err     <= 1'b0;
      overflow_err    <= 1'b0;
      match_count     <= '0;
      r_lead          <= '0;
    end else if (w_run) begin
      if (w_mis) begin
        mismatch        <= 1'b1;
        mismatch_fields <= w_fields;
        mismatch_pc     <= w_dut_head.pc;
      end
      if (w_match && (match_count != 32'hFFFF_FFFF))
        match_count <= match_count + 32'd1;
      if (w_tmo) timeout_err  <= 1'b1;
      if (w_ovf) overflow_err <= 1'b1;
      r_lead <= w_lead_one ? r_lead + LW'(1) : '0;
    end
  end

  assign running = w_run;

endmodule

// File: tb/tb_commit_checker.sv
// Randomized and directed bench for commit_checker against a queue-based reference model.
module tb_commit_checker;
  import commit_chk_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clr;
  logic                  dut_valid, ref_valid;
  commit_rec_t           dut_rec_s, ref_rec_s;
  logic                  mismatch;
  logic [NUM_FIELDS-1:0] mismatch_fields;
  logic [63:0]           mismatch_pc;
  logic                  timeout_err, overflow_err, running;
  logic [31:0]           match_count;

  int checks = 0;
  int errors = 0;

  commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .dut_valid(dut_valid), .dut_rec(dut_rec_s),
    .ref_valid(ref_valid), .ref_rec(ref_rec_s),
    .mismatch(mismatch), .mismatch_fields(mismatch_fields), .mismatch_pc(mismatch_pc),
    .timeout_err(timeout_err), .overflow_err(overflow_err),
    .match_count(match_count), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model state
  commit_rec_t mdq[$];
  commit_rec_t mrq[$];
  bit          m_fail, m_mis, m_tmo, m_ovf;
  logic [8:0]  m_fields;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  int          m_lead;
  commit_rec_t pend[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_mask(commit_rec_t d, commit_rec_t r);
    logic [8:0] diff, relevant;
    bit both_trap;
    both_trap = d.trap && r.trap;
    diff = {d.priv != r.priv, d.trap != r.trap, d.mem_wdata != r.mem_wdata,
            d.mem_addr != r.mem_addr, d.mem_we != r.mem_we, d.rd_data != r.rd_data,
            d.rd_addr != r.rd_addr, d.instr != r.instr, d.pc != r.pc};
    if (both_trap) relevant = 9'b1_1000_0001;
    else begin
      relevant = 9'h1FF;
      if (d.rd_addr == 0 && r.rd_addr == 0) relevant[3] = 1'b0;
      if (!d.mem_we && !r.mem_we) relevant[6:5] = 2'b00;
    end
`ifndef COMMIT_CHK_PRIV_EN
    relevant[8] = 1'b0;
`endif
    return diff & relevant;
  endfunction

  task automatic model_reset();
    mdq.delete(); mrq.delete();
    m_fail = 0; m_mis = 0; m_tmo = 0; m_ovf = 0;
    m_fields = '0; m_pc = '0; m_cnt = '0; m_lead = 0;
  endtask

  task automatic model_step();
    bit pop, err;
    logic [8:0] mk;
    if (clr) begin model_reset(); return; end
    if (m_fail) return;
    err = 0;
    pop = (mdq.size() > 0) && (mrq.size() > 0);
    if (pop) begin
      mk = exp_mask(mdq[0], mrq[0]);
      if (mk != 0) begin
        m_mis = 1; m_fields = mk; m_pc = mdq[0].pc; err = 1;
      end else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      void'(mdq.pop_front()); void'(mrq.pop_front());
    end else if ((mdq.size() > 0) != (mrq.size() > 0)) begin
      m_lead++;
      if (m_lead >= TIMEOUT) begin m_tmo = 1; err = 1; end
    end else m_lead = 0;
    if (pop) m_lead = 0;
    if (dut_valid) begin
      if (mdq.size() < DEPTH) mdq.push_back(dut_rec_s);
      else begin m_ovf = 1; err = 1; end
    end
    if (ref_valid) begin
      if (mrq.size() < DEPTH) mrq.push_back(ref_rec_s);
      else begin m_ovf = 1; err = 1; end
    end
    if (err) m_fail = 1;
  endtask

  task automatic cmp_model();
    chk("running", running, !m_fail);
    chk("mismatch", mismatch, m_mis);
    chk("mismatch_fields", mismatch_fields, m_fields);
    chk("mismatch_pc", mismatch_pc, m_pc);
    chk("timeout_err", timeout_err, m_tmo);
    chk("overflow_err", overflow_err, m_ovf);
    chk("match_count", match_count, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
    dut_valid = 0; ref_valid = 0; clr = 0;
  endtask

  task automatic send_pair(input commit_rec_t d, input commit_rec_t r);
    dut_valid = 1; dut_rec_s = d; ref_valid = 1; ref_rec_s = r;
    step();
  endtask

  task automatic do_clr();
    clr = 1;
    step();
  endtask

  function automatic commit_rec_t base_rec();
    commit_rec_t c;
    c = '0;
    c.pc = 64'h8000_0000; c.instr = 32'h0010_0093;
    c.rd_addr = 5'd1; c.rd_data = 64'd1; c.priv = PRIV_M;
    return c;
  endfunction

  function automatic commit_rec_t rand_rec();
    commit_rec_t c;
    c.pc        = 64'(32'h8000_0000 + ($urandom_range(0, 255) << 2));
    c.instr     = $urandom;
    c.rd_addr   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
    c.rd_data   = {$urandom, $urandom};
    c.mem_we    = 1'($urandom);
    c.mem_addr  = {$urandom, $urandom};
    c.mem_wdata = {$urandom, $urandom};
    c.trap      = ($urandom_range(0, 7) == 0);
    case ($urandom_range(0, 2))
      0:       c.priv = PRIV_U;
      1:       c.priv = PRIV_S;
      default: c.priv = PRIV_M;
    endcase
    return c;
  endfunction

  function automatic commit_rec_t corrupt(commit_rec_t c);
    commit_rec_t o;
    o = c;
    case ($urandom_range(0, 8))
      0: o.pc        = c.pc ^ 64'h4;
      1: o.instr     = c.instr ^ 32'h100;
      2: o.rd_addr   = c.rd_addr ^ 5'h1;
      3: o.rd_data   = c.rd_data ^ 64'h1;
      4: o.mem_we    = ~c.mem_we;
      5: o.mem_addr  = c.mem_addr ^ 64'h8;
      6: o.mem_wdata = c.mem_wdata ^ 64'h2;
      7: o.trap      = ~c.trap;
      default: o.priv = (c.priv == PRIV_M) ? PRIV_U : PRIV_M;
    endcase
    return o;
  endfunction

  initial begin
    commit_rec_t d, r;
    rst_n = 0; clr = 0; dut_valid = 0; ref_valid = 0;
    dut_rec_s = '0; ref_rec_s = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_running", running, 1);
    chk("reset_mismatch", mismatch, 0);
    chk("reset_count", match_count, 0);
    chk("reset_flags", {timeout_err, overflow_err}, 0);
    rst_n = 1;

    // Identical addi on both sides
    send_pair(base_rec(), base_rec());
    step();
    chk("addi_count", match_count, 1);
    chk("addi_mismatch", mismatch, 0);

    // Don't-care fields: rd_data with rd_addr=0, mem_wdata with mem_we=0
    d = base_rec(); d.rd_addr = 0; d.rd_data = 64'd7;
    r = d; r.rd_data = 64'd9;
    send_pair(d, r);
    d = base_rec(); d.mem_wdata = 64'd1;
    r = d; r.mem_wdata = 64'd2;
    send_pair(d, r);
    step();
    chk("dontcare_count", match_count, 3);
    chk("dontcare_mismatch", mismatch, 0);

    // rd_data mismatch, then later traffic ignored
    d = base_rec(); d.rd_addr = 5'd3; d.rd_data = 64'h5;
    r = d; r.rd_data = 64'h6;
    send_pair(d, r);
    step();
    chk("rd_mis_flag", mismatch, 1);
    chk("rd_mis_fields", mismatch_fields, 9'h008);
    chk("rd_mis_pc", mismatch_pc, 64'h8000_0000);
    chk("rd_mis_running", running, 0);
    send_pair(base_rec(), base_rec());
    step();
    chk("fail_hold_count", match_count, 3);
    chk("fail_hold_fields", mismatch_fields, 9'h008);
    do_clr();
    chk("clr_all", {mismatch, timeout_err, overflow_err, mismatch_fields}, 0);
    chk("clr_running", running, 1);

    // Lead timeout: DUT one record, reference silent
    dut_valid = 1; dut_rec_s = base_rec();
    step();
    repeat (TIMEOUT - 1) step();
    chk("tmo_before", timeout_err, 0);
    step();
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_running", running, 0);
    do_clr();

    // Overflow on fifth consecutive DUT push
    for (int i = 0; i < 5; i++) begin
      dut_valid = 1; dut_rec_s = base_rec();
      step();
      if (i == 3) chk("ovf_before", overflow_err, 0);
    end
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_running", running, 0);
    do_clr();
    chk("ovf_clr", {overflow_err, mismatch, timeout_err, running}, 4'b0001);

    // priv 3 vs 1
    d = base_rec(); d.priv = PRIV_M;
    r = d; r.priv = PRIV_S;
    send_pair(d, r);
    step();
`ifdef COMMIT_CHK_PRIV_EN
    chk("priv_mis", mismatch, 1);
    chk("priv_fields", mismatch_fields, 9'h100);
`else
    chk("priv_ign", mismatch, 0);
    chk("priv_count", match_count, 1);
`endif
    do_clr();

    // Reset mid-operation discards queued records silently
    dut_valid = 1; dut_rec_s = rand_rec(); step();
    dut_valid = 1; dut_rec_s = rand_rec(); step();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("midrst_flags", {mismatch, timeout_err, overflow_err, running}, 4'b0001);
    @(negedge clk) rst_n = 1;
    send_pair(base_rec(), base_rec());
    step();
    chk("midrst_count", match_count, 1);
    chk("midrst_mismatch", mismatch, 0);

    // Randomized traffic with occasional corruption; recover via clr
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((m_fail && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        clr = 1;
        pend.delete();
      end else begin
        if ($urandom_range(0, 2) != 0) begin
          d = rand_rec();
          dut_valid = 1; dut_rec_s = d;
          pend.push_back(d);
        end
        if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          r = pend.pop_front();
          if ($urandom_range(0, 59) == 0) r = corrupt(r);
          ref_valid = 1; ref_rec_s = r;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
